// File: rtl/seg_msg_arbiter.sv
`default_nettype none
// ============================================================================
// seg_msg_arbiter: two-requester message arbiter and 4-digit 7-seg scanner.
// Revision: 1.0
// ============================================================================
module seg_msg_arbiter #(
  parameter int HOLD_CYCLES = 16384
) (
  input  logic        segclk,
  input  logic        clr,
  input  logic        req_a,
  input  logic [19:0] msg_a,
  input  logic        req_b,
  input  logic [19:0] msg_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic        busy,
  output logic        owner,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int             c_CW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(HOLD_CYCLES - 1);
  localparam logic [6:0]      c_BLANK = 7'b1111111;
  localparam logic [3:0]      c_AN_OFF = 4'b1111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SHOW = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [19:0]     r_msg;
  logic [c_CW-1:0] r_cnt;
  logic [1:0]      r_scan;
  logic [6:0]      r_seg;
  logic [3:0]      r_an;
  logic            r_ack_a;
  logic            r_ack_b;
  logic            r_owner;
  logic            w_expire;
  logic            w_latch_a;
  logic            w_latch_b;
  logic [4:0]      w_char;
  logic [3:0]      w_an_scan;

  function automatic logic [6:0] f_glyph(input logic [4:0] i_code);
    logic [6:0] v;
    case (i_code)
      5'd0:    v = 7'b0001000; // A
      5'd1:    v = 7'b0000011; // b
      5'd2:    v = 7'b1000110; // C
      5'd3:    v = 7'b0100001; // d
      5'd4:    v = 7'b0000110; // E
      5'd5:    v = 7'b0001110; // F
      5'd6:    v = 7'b1000010; // G
      5'd7:    v = 7'b0001001; // H
      5'd8:    v = 7'b1001111; // I
      5'd9:    v = 7'b1100001; // J
      5'd10:   v = 7'b0001010; // K
      5'd11:   v = 7'b1000111; // L
      5'd12:   v = 7'b1101010; // M
      5'd13:   v = 7'b1001000; // N
      5'd14:   v = 7'b1000000; // O
      5'd15:   v = 7'b0001100; // P
      5'd16:   v = 7'b0011000; // q
      5'd17:   v = 7'b1001100; // R
      5'd18:   v = 7'b0010010; // S
      5'd19:   v = 7'b0000111; // t
      5'd20:   v = 7'b1000001; // U
      5'd21:   v = 7'b1100011; // v
      5'd22:   v = 7'b1010101; // W
      5'd23:   v = 7'b0011011; // X
      5'd24:   v = 7'b0010001; // y
      5'd25:   v = 7'b0100100; // Z
      default: v = c_BLANK;
    endcase
    return v;
  endfunction

  assign w_expire = (r_state == S_SHOW) && (r_cnt == c_LAST);

  // In IDLE A has fixed priority; at expiry the non-owner is preferred.
  always_comb begin
    w_state_nxt = r_state;
    w_latch_a   = 1'b0;
    w_latch_b   = 1'b0;
    if (r_state == S_IDLE) begin
      if (req_a)      w_latch_a = 1'b1;
      else if (req_b) w_latch_b = 1'b1;
    end else if (w_expire) begin
      w_state_nxt = S_IDLE;
      if (r_owner) begin
        if (req_b)      w_latch_b = 1'b1;
        else if (req_a) w_latch_a = 1'b1;
      end else begin
        if (req_a)      w_latch_a = 1'b1;
        else if (req_b) w_latch_b = 1'b1;
      end
    end
    if (w_latch_a || w_latch_b) w_state_nxt = S_SHOW;
  end

  always_comb begin
    w_char    = r_msg[4:0];
    w_an_scan = 4'b1110;
    case (r_scan)
      2'd0:    begin w_char = r_msg[19:15]; w_an_scan = 4'b0111; end
      2'd1:    begin w_char = r_msg[14:10]; w_an_scan = 4'b1011; end
      2'd2:    begin w_char = r_msg[9:5];   w_an_scan = 4'b1101; end
      default: begin w_char = r_msg[4:0];   w_an_scan = 4'b1110; end
    endcase
  end

  always_ff @(posedge segclk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_msg   <= '0;
      r_cnt   <= '0;
      r_scan  <= '0;
      r_seg   <= c_BLANK;
      r_an    <= c_AN_OFF;
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack_a <= w_latch_a;
      r_ack_b <= w_latch_b;
      if (w_latch_a || w_latch_b) begin
        r_msg   <= w_latch_a ? msg_a : msg_b;
        r_owner <= w_latch_a;
        r_cnt   <= '0;
        r_scan  <= '0;
        r_seg   <= c_BLANK;
        r_an    <= c_AN_OFF;
      end else if ((r_state == S_SHOW) && !w_expire) begin
        r_seg  <= f_glyph(w_char);
        r_an   <= w_an_scan;
        r_scan <= r_scan + 2'd1;
        r_cnt  <= r_cnt + 1'b1;
      end else begin
        r_seg <= c_BLANK;
        r_an  <= c_AN_OFF;
      end
    end
  end

  assign ack_a = r_ack_a;
  assign ack_b = r_ack_b;
  assign busy  = (r_state == S_SHOW);
  assign owner = r_owner;
  assign seg   = r_seg;
  assign an    = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seg_msg_arbiter.sv
`default_nettype none
// ============================================================================
// tb_seg_msg_arbiter: vector-table bench with expected-output queue.
// Revision: 1.0
// ============================================================================
module tb_seg_msg_arbiter;

  localparam logic [6:0]  c_BLK  = 7'b1111111;
  localparam logic [3:0]  c_OFF  = 4'b1111;
  localparam logic [19:0] c_NERP = {5'd13, 5'd4, 5'd17, 5'd15};
  localparam logic [19:0] c_BLNK = {5'd26, 5'd27, 5'd30, 5'd31};

  logic        segclk = 1'b0;
  logic        clr = 1'b1;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [19:0] msg_a = c_NERP;
  logic [19:0] msg_b = c_BLNK;
  logic        ack_a, ack_b, busy, owner;
  logic [6:0]  seg;
  logic [3:0]  an;

  seg_msg_arbiter #(.HOLD_CYCLES(8)) dut (
    .segclk(segclk), .clr(clr),
    .req_a(req_a), .msg_a(msg_a), .req_b(req_b), .msg_b(msg_b),
    .ack_a(ack_a), .ack_b(ack_b), .busy(busy), .owner(owner),
    .seg(seg), .an(an)
  );

  always #5 segclk = ~segclk;

  typedef struct {
    logic       clr, ra, rb;
    logic       eaa, eab, ebusy, eown;
    logic [6:0] eseg;
    logic [3:0] ean;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // NERP glyphs and digit enables by scan index
  logic [6:0] g_nerp [4] = '{7'b1001000, 7'b0000110, 7'b1001100, 7'b0001100};
  logic [3:0] an_scan [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  function automatic void add(input logic c, ra, rb, eaa, eab, ebusy, eown,
                              input logic [6:0] eseg, input logic [3:0] ean);
    vec_t v;
    v.clr = c; v.ra = ra; v.rb = rb;
    v.eaa = eaa; v.eab = eab; v.ebusy = ebusy; v.eown = eown;
    v.eseg = eseg; v.ean = ean;
    tbl.push_back(v);
  endfunction

  // n display edges starting at scan index 'first', no acks
  function automatic void add_show(input logic ra, rb, own, nerp, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      k = (first + i) % 4;
      add(1'b0, ra, rb, 1'b0, 1'b0, 1'b1, own, nerp ? g_nerp[k] : c_BLK, an_scan[k]);
    end
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, expv);
    end
  endtask

  initial begin
    // reset
    add(1, 0, 0, 0, 0, 0, 0, c_BLK, c_OFF);
    add(1, 0, 0, 0, 0, 0, 0, c_BLK, c_OFF);
    add(0, 0, 0, 0, 0, 0, 0, c_BLK, c_OFF);
    // single request from IDLE, return to IDLE 8 edges after latch
    add(0, 1, 0, 1, 0, 1, 1, c_BLK, c_OFF);
    add_show(1, 0, 1, 1, 0, 1);
    add_show(0, 0, 1, 1, 1, 6);
    add(0, 0, 0, 0, 0, 0, 1, c_BLK, c_OFF);
    add(0, 0, 0, 0, 0, 0, 1, c_BLK, c_OFF);
    // reset mid-SHOW at cnt=3 with B pending
    add(0, 1, 0, 1, 0, 1, 1, c_BLK, c_OFF);
    add_show(1, 0, 1, 1, 0, 1);
    add_show(0, 0, 1, 1, 1, 2);
    add(1, 0, 1, 0, 0, 0, 0, c_BLK, c_OFF);
    add(1, 0, 1, 0, 0, 0, 0, c_BLK, c_OFF);
    add(0, 0, 0, 0, 0, 0, 0, c_BLK, c_OFF);
    // simultaneous requests; B acked 8 edges later, B shows blank codes
    add(0, 1, 1, 1, 0, 1, 1, c_BLK, c_OFF);
    add_show(1, 1, 1, 1, 0, 1);
    add_show(0, 1, 1, 1, 1, 6);
    add(0, 0, 1, 0, 1, 1, 0, c_BLK, c_OFF);
    add_show(0, 1, 0, 0, 0, 1);
    add_show(0, 0, 0, 0, 1, 6);
    add(0, 0, 0, 0, 0, 0, 0, c_BLK, c_OFF);
    // round-robin with A continuous, then same-owner re-latch
    add(0, 1, 0, 1, 0, 1, 1, c_BLK, c_OFF);
    add_show(1, 0, 1, 1, 0, 3);
    add_show(1, 1, 1, 1, 3, 4);
    add(0, 1, 1, 0, 1, 1, 0, c_BLK, c_OFF);
    add_show(1, 1, 0, 0, 0, 1);
    add_show(1, 0, 0, 0, 1, 6);
    add(0, 1, 0, 1, 0, 1, 1, c_BLK, c_OFF);
    add_show(1, 0, 1, 1, 0, 7);
    add(0, 1, 0, 1, 0, 1, 1, c_BLK, c_OFF);
    add_show(1, 0, 1, 1, 0, 1);
    add_show(0, 0, 1, 1, 1, 6);
    add(0, 0, 0, 0, 0, 0, 1, c_BLK, c_OFF);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t e;
      @(negedge segclk);
      clr   = tbl[i].clr;
      req_a = tbl[i].ra;
      req_b = tbl[i].rb;
      exp_q.push_back(tbl[i]);
      @(posedge segclk);
      #1;
      e = exp_q.pop_front();
      chk("ack_a", i, {31'd0, ack_a}, {31'd0, e.eaa});
      chk("ack_b", i, {31'd0, ack_b}, {31'd0, e.eab});
      chk("busy",  i, {31'd0, busy},  {31'd0, e.ebusy});
      chk("owner", i, {31'd0, owner}, {31'd0, e.eown});
      chk("seg",   i, {25'd0, seg},   {25'd0, e.eseg});
      chk("an",    i, {28'd0, an},    {28'd0, e.ean});
      chk("ack_excl", i, {31'd0, ack_a & ack_b}, 32'd0);
    end
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_msg_arbiter.md
# seg_msg_arbiter

Display-message arbiter and scan controller for the 4-digit 7-segment display. It accepts 4-character messages from two requesters: A is the game/alert path and B is the status path. It grants the display to one requester at a time and holds each granted message for a fixed number of cycles. While a message is held, it scans the message's characters across the digits so they appear simultaneously. It owns the seg/an pins and replaces the fixed-text display driver.

## Interface
- HOLD_CYCLES, 16384: `segclk` cycles a granted message occupies the display, counted from the latch edge; minimum 4.
- segclk  in  1  display scan clock; all logic on rising edge.
- clr  in  1  synchronous, active-high reset.
- req_a  in  1  requester A wants the display. Level; held until ack_a.
- msg_a  in  20  A's message. Four 5-bit char codes; [19:15] is the leftmost digit, [4:0] the rightmost.
- req_b  in  1  requester B request, same rules as A.
- msg_b  in  20  B's message, same format as msg_a.
- ack_a  out  1  one-cycle pulse: msg_a has been latched.
- ack_b  out  1  one-cycle pulse: msg_b has been latched.
- busy  out  1  a message is on display (state SHOW).
- owner  out  1  owner of the current or last message: 1 = A, 0 = B.
- seg  out  7  segment drive, active-low, {g,f,e,d,c,b,a}.
- an  out  4  digit enables, active-low; an[3] is the leftmost digit.

## Operation
- Requester protocol:
  - msg_x must be stable while req_x is high.
  - The requester drops req_x at the edge where it samples ack_x = 1.
- Char codes and glyphs:
  - 0–25 = A–Z; 26–31 = blank (7'b1111111).
  - Glyphs come from the team letter table. Mandatory values: E = 7'b0000110, N = 7'b1001000, P = 7'b0001100, R = 7'b1001100.
- States: IDLE and SHOW.
- Registers:
  - msg_q, 20 bits.
  - cnt, hold counter, $clog2(HOLD_CYCLES) bits.
  - scan, 2-bit digit index.
- IDLE:
  - Outputs: seg = 7'b1111111, an = 4'b1111, busy = 0.
  - If req_a: latch msg_a, owner <= 1. Else if req_b: latch msg_b, owner <= 0. In IDLE, A has fixed priority.
- Latch edge, applies to every latch:
  - msg_q <= msg; cnt <= 0; scan <= 0; state <= SHOW.
  - seg <= 7'b1111111 and an <= 4'b1111, giving one blanking cycle.
  - ack_x <= 1 for exactly the next cycle.
- SHOW, each non-latch edge:
  - seg <= glyph(msg_q char[scan]).
  - an <= 0111 / 1011 / 1101 / 1110 for scan = 0 / 1 / 2 / 3.
  - scan <= scan + 1, wrapping 3 → 0.
  - cnt <= cnt + 1.
- Expiry: at an edge in SHOW where cnt == HOLD_CYCLES−1.
  - Round-robin: the requester that is not the current owner wins if it is requesting.
  - Otherwise the current owner wins if it is still requesting; the winner is latched.
  - If neither requests: state <= IDLE, outputs blank, owner holds.
- Requests arriving during SHOW before expiry are not acked and not lost; they are evaluated at expiry. There is no preemption.
- ack_a and ack_b are never high together; at most one latch happens per edge.

## Timing
- Reset: while clr is sampled high, the next edge sets:
  - state IDLE; seg = 7'b1111111; an = 4'b1111.
  - ack_a = ack_b = 0; busy = 0; owner = 0; cnt = 0; scan = 0; msg_q = 0.
  - clr overrides all other activity, including mid-SHOW and on the latch edge. A pending request is not acked.
  - The first edge with clr low evaluates requests normally.
- Latency:
  - req_x sampled high in IDLE → latch on that edge. ack_x and busy are high in the following cycle, with outputs blank.
  - The first digit (an = 4'b0111) is driven after the second edge.
- Occupancy: the next latch, or the return to IDLE, happens exactly HOLD_CYCLES edges after the latch edge.
- Refresh: each digit is lit 1 cycle in 4.
- Back-to-back handoff at expiry: one blank cycle, then scanning restarts at digit 0.

## Test plan
All scenarios use HOLD_CYCLES = 8.
- Reset mid-SHOW: A latched with "NERP" (codes 13, 4, 17, 15), clr pulsed at cnt = 3.
  - Next edge: seg = 1111111, an = 1111, busy = 0, owner = 0.
  - No ack from that edge on.
- Single request: req_a with "NERP" from IDLE.
  - ack_a pulses 1 cycle; busy rises in the same cycle; one blank cycle.
  - Then seg/an = 1001000/0111, 0000110/1011, 1001100/1101, 0001100/1110, repeating.
  - Returns to IDLE exactly 8 edges after the latch.
- Simultaneous req_a and req_b in IDLE:
  - ack_a only; owner = 1.
  - B is acked exactly 8 edges later; owner = 0.
- Round-robin: A re-requests continuously, B requests during A's hold.
  - Expiry grants B, then A, alternating; neither is starved.
- Same owner re-request: only A requesting at expiry.
  - A is re-latched; ack_a pulses; one blank cycle; busy stays 1.
- Blank codes: message {26, 27, 30, 31}.
  - seg = 1111111 on all digits while an still scans.
